byte_serializer: RTL and testbench

Downstream stage of the nibble-swap datapath. Accepts swapped 8-bit bytes over a valid/ready handshake and serialises each one onto a 1-bit output, paced by an external bit tick. An optional parity bit is appended. A one-entry holding buffer allows back-to-back frames with no idle bit slot between them.

---
 rtl/byte_serializer_pkg.sv | 29 ++
 rtl/ser_skid_buf.sv | 53 +++++
 rtl/byte_serializer.sv | 173 +++++++++++++++++
 tb/tb_byte_serializer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_serializer_pkg.sv
// -----------------------------------------------------------------------------
// byte_serializer_pkg
// Shared types and helpers for the byte serializer:
//   - ser_state_t : frame FSM states (idle, payload shift, parity slot)
//   - BIT_CNT_W   : bit counter width for the default 8-bit payload
//   - bit_cnt_width() : counter width for an arbitrary payload width
//   - parity_bit()    : even/odd parity over a (zero-extended) payload
// -----------------------------------------------------------------------------
package byte_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } ser_state_t;

    localparam int DATA_W_DEFAULT = 8;
    localparam int BIT_CNT_W      = $clog2(DATA_W_DEFAULT + 1);

    function automatic int bit_cnt_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

    // Zero-extension of the payload does not change its XOR reduction.
    function automatic logic parity_bit(input logic [63:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/ser_skid_buf.sv
// -----------------------------------------------------------------------------
// ser_skid_buf
// One-entry holding register in front of the serializer shifter.
// Ports:
//   clk, reset   : clock, async active-low reset
//   i_valid/i_data : upstream byte offer
//   i_busy       : serializer is mid-frame (not idle)
//   i_eof        : this edge ends the current frame
//   o_ready      : upstream may hand over a byte this cycle
//   o_accept     : handshake completes on this edge
//   o_full/o_data: buffered byte waiting for the next frame
// -----------------------------------------------------------------------------
module ser_skid_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_busy,
    input  logic              i_eof,
    output logic              o_ready,
    output logic              o_accept,
    output logic              o_full,
    output logic [DATA_W-1:0] o_data
);

    logic              r_full;
    logic [DATA_W-1:0] r_data;

    // Ready drops while reset is asserted so nothing is taken during reset.
    assign o_ready  = reset & ~r_full;
    assign o_accept = i_valid & o_ready;
    assign o_full   = r_full;
    assign o_data   = r_data;

    // Buffer fill/drain: the serializer drains it at end-of-frame; a byte
    // offered mid-frame parks here. Idle or end-of-frame accepts bypass it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full <= 1'b0;
            r_data <= {DATA_W{1'b0}};
        end else if (i_eof && r_full) begin
            r_full <= 1'b0;
        end else if (o_accept && i_busy && !i_eof) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else begin
            r_full <= r_full;
        end
    end

endmodule

// File: rtl/byte_serializer.sv
// -----------------------------------------------------------------------------
// byte_serializer
// Serialises bytes from the nibble-swap stage onto a 1-bit output, one bit per
// bit_tick, with an optional trailing parity bit. A one-entry buffer lets the
// next frame start on the tick that ends the current one.
// Ports:
//   clk, reset           : clock, async active-low reset
//   in_data/in_valid/in_ready : byte input handshake
//   bit_tick             : advance the serial output by one bit
//   ser_out/ser_valid    : serial bit and its qualifier
//   ser_start/ser_last   : first payload bit / final bit of a frame
//   frame_cnt            : completed frames (wrapping)
// -----------------------------------------------------------------------------
module byte_serializer
    import byte_serializer_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LSB_FIRST  = 0,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              bit_tick,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              ser_start,
    output logic              ser_last,
    output logic [15:0]       frame_cnt
);

    localparam int               CNT_W    = bit_cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic             LSB_B    = (LSB_FIRST != 0);
    localparam logic             PAR_EN_B = (PARITY_EN != 0);
    localparam logic             PAR_ODD_B = (PARITY_ODD != 0);

    ser_state_t        r_state,     w_state_nxt;
    logic [DATA_W-1:0] r_shift,     w_shift_nxt;
    logic [CNT_W-1:0]  r_bit_cnt,   w_cnt_nxt;
    logic              r_par,       w_par_nxt;
    logic [15:0]       r_frame_cnt, w_fc_nxt;

    logic              w_accept;
    logic              w_buf_full;
    logic [DATA_W-1:0] w_buf_data;
    logic              w_busy;
    logic              w_at_last;
    logic              w_eof;
    logic              w_load;
    logic [DATA_W-1:0] w_load_data;
    logic [DATA_W-1:0] w_shifted;
    logic              w_cur_bit;

    assign w_busy    = (r_state != ST_IDLE);
    assign w_at_last = (r_bit_cnt == LAST_CNT);
    // End-of-frame is the tick on the final bit: parity slot, or last payload
    // bit when no parity is appended.
    assign w_eof     = bit_tick & ((r_state == ST_PARITY) |
                                   ((r_state == ST_SHIFT) & w_at_last & ~PAR_EN_B));
    assign w_shifted = LSB_B ? (r_shift >> 1'b1) : (r_shift << 1'b1);
    assign w_cur_bit = LSB_B ? r_shift[0] : r_shift[DATA_W-1];

    ser_skid_buf #(.DATA_W(DATA_W)) u_skid (
        .clk      (clk),
        .reset    (reset),
        .i_valid  (in_valid),
        .i_data   (in_data),
        .i_busy   (w_busy),
        .i_eof    (w_eof),
        .o_ready  (in_ready),
        .o_accept (w_accept),
        .o_full   (w_buf_full),
        .o_data   (w_buf_data)
    );

    // Next-state: per-state shifting, then end-of-frame reload, then the
    // common load action (new frame always starts at bit 0 in SHIFT).
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_bit_cnt;
        w_par_nxt   = r_par;
        w_fc_nxt    = r_frame_cnt;
        w_load      = 1'b0;
        w_load_data = in_data;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_load = 1'b1;
                end else begin
                    w_load = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (bit_tick) begin
                    w_shift_nxt = w_shifted;
                    w_cnt_nxt   = r_bit_cnt + CNT_ONE;
                    if (w_at_last && PAR_EN_B) begin
                        w_state_nxt = ST_PARITY;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_PARITY: begin
                w_state_nxt = r_state;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_eof) begin
            w_fc_nxt = r_frame_cnt + 16'd1;
            if (w_buf_full) begin
                w_load      = 1'b1;
                w_load_data = w_buf_data;
            end else if (w_accept) begin
                w_load      = 1'b1;
                w_load_data = in_data;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end else begin
            w_fc_nxt = r_frame_cnt;
        end

        // Parity is latched from the byte as loaded, independent of shifting.
        if (w_load) begin
            w_shift_nxt = w_load_data;
            w_cnt_nxt   = {CNT_W{1'b0}};
            w_par_nxt   = parity_bit(64'(w_load_data), PAR_ODD_B);
            w_state_nxt = ST_SHIFT;
        end else begin
            w_shift_nxt = w_shift_nxt;
        end
    end

    // Frame state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_shift     <= {DATA_W{1'b0}};
            r_bit_cnt   <= {CNT_W{1'b0}};
            r_par       <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_bit_cnt   <= w_cnt_nxt;
            r_par       <= w_par_nxt;
            r_frame_cnt <= w_fc_nxt;
        end
    end

    // Serial outputs decode registered state only.
    assign ser_valid = (r_state == ST_SHIFT) | (r_state == ST_PARITY);
    assign ser_out   = ((r_state == ST_SHIFT) & w_cur_bit) |
                       ((r_state == ST_PARITY) & r_par);
    assign ser_start = (r_state == ST_SHIFT) & (r_bit_cnt == {CNT_W{1'b0}});
    assign ser_last  = (r_state == ST_PARITY) |
                       ((r_state == ST_SHIFT) & w_at_last & ~PAR_EN_B);
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_byte_serializer.sv
module tb_byte_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       bit_tick = 1'b0;
    logic       v1 = 1'b0, v2 = 1'b0;

    logic        d1_ready, d1_out, d1_valid, d1_start, d1_last;
    logic [15:0] d1_fc;
    logic        d2_ready, d2_out, d2_valid, d2_start, d2_last;
    logic [15:0] d2_fc;

    int checks = 0;
    int failures = 0;
    int fc1 = 0, fc2 = 0;

    logic [2:0] got_q[$];   // {ser_out, ser_start, ser_last} at each consumed bit
    logic [7:0] acc_q[$];   // bytes accepted by dut1, in order

    typedef struct {
        logic       sel;    // 0: default config, 1: LSB-first odd-parity
        logic [7:0] data;
        logic [8:0] pat;    // pat[8] is the first bit on the line, pat[0] parity
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    byte_serializer dut1 (
        .clk(clk), .reset(rst_n), .in_data(in_data), .in_valid(v1), .in_ready(d1_ready),
        .bit_tick(bit_tick), .ser_out(d1_out), .ser_valid(d1_valid),
        .ser_start(d1_start), .ser_last(d1_last), .frame_cnt(d1_fc)
    );

    byte_serializer #(.LSB_FIRST(1), .PARITY_ODD(1)) dut2 (
        .clk(clk), .reset(rst_n), .in_data(in_data), .in_valid(v2), .in_ready(d2_ready),
        .bit_tick(bit_tick), .ser_out(d2_out), .ser_valid(d2_valid),
        .ser_start(d2_start), .ser_last(d2_last), .frame_cnt(d2_fc)
    );

    // Observe dut1 on the falling edge: bits consumed by a tick, bytes accepted.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bit_tick && d1_valid) got_q.push_back({d1_out, d1_start, d1_last});
            if (v1 && d1_ready) acc_q.push_back(in_data);
        end
    end

    // Reference: the frame as it should appear on the wire.
    function automatic logic [8:0] frame_pat(logic [7:0] b, bit lsb, bit odd);
        logic [8:0] p;
        int ones;
        ones = $countones(b);
        for (int i = 0; i < 8; i++) p[8-i] = lsb ? b[i] : b[7-i];
        p[0] = ((ones % 2) == 1) ^ odd;
        return p;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!d1_valid) break;
            cycle();
        end
        check("idle_timeout", {31'd0, d1_valid}, 32'd0);
    endtask

    // Every consumed bit must match the concatenated frames of accepted bytes.
    task automatic compare_stream();
        int n;
        logic [8:0] p;
        logic [2:0] e;
        check("stream_len", got_q.size(), acc_q.size() * 9);
        n = (got_q.size() < acc_q.size() * 9) ? got_q.size() : acc_q.size() * 9;
        for (int i = 0; i < n; i++) begin
            p = frame_pat(acc_q[i/9], 1'b0, 1'b0);
            e = {p[8 - (i % 9)], (i % 9) == 0, (i % 9) == 8};
            check("stream_bit", {29'd0, got_q[i]}, {29'd0, e});
        end
        got_q.delete();
        acc_q.delete();
    endtask

    task automatic run_vec(vec_t v);
        in_data = v.data;
        bit_tick = 1'b1;
        if (v.sel) v2 = 1'b1; else v1 = 1'b1;
        cycle();
        v1 = 1'b0;
        v2 = 1'b0;
        for (int j = 0; j < 9; j++) begin
            check("vec_valid", {31'd0, v.sel ? d2_valid : d1_valid}, 32'd1);
            check("vec_bit",   {31'd0, v.sel ? d2_out : d1_out}, {31'd0, v.pat[8-j]});
            check("vec_start", {31'd0, v.sel ? d2_start : d1_start}, {31'd0, j == 0});
            check("vec_last",  {31'd0, v.sel ? d2_last : d1_last}, {31'd0, j == 8});
            cycle();
        end
        check("vec_end_valid", {31'd0, v.sel ? d2_valid : d1_valid}, 32'd0);
        if (v.sel) begin
            fc2++;
            check("vec_fc2", {16'd0, d2_fc}, fc2);
        end else begin
            fc1++;
            check("vec_fc1", {16'd0, d1_fc}, fc1);
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 8'hA5, 9'b1010_0101_0};
        vecs[1] = '{1'b1, 8'h3C, 9'b0011_1100_1};
        vecs[2] = '{1'b0, 8'h3C, 9'b0011_1100_0};
        vecs[3] = '{1'b0, 8'h7F, 9'b0111_1111_1};
        vecs[4] = '{1'b0, 8'h01, 9'b0000_0001_1};
        vecs[5] = '{1'b1, 8'h01, 9'b1000_0000_0};
        vecs[6] = '{1'b0, 8'h00, 9'b0000_0000_0};
        vecs[7] = '{1'b0, 8'hFF, 9'b1111_1111_0};

        // Reset state
        cycle();
        cycle();
        check("rst_ready", {31'd0, d1_ready}, 32'd0);
        check("rst_valid", {31'd0, d1_valid}, 32'd0);
        check("rst_out",   {31'd0, d1_out}, 32'd0);
        check("rst_fc",    {16'd0, d1_fc}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", {31'd0, d1_ready}, 32'd1);
        cycle();

        // Single frames from the table, tick every cycle
        for (int k = 0; k < 8; k++) run_vec(vecs[k]);
        compare_stream();

        // Back-to-back 8'h12 then 8'h34: 18 valid cycles, second start at index 9
        bit_tick = 1'b1;
        in_data = 8'h12;
        v1 = 1'b1;
        cycle();
        in_data = 8'h34;
        check("b2b_ready", {31'd0, d1_ready}, 32'd1);
        for (int k = 0; k < 18; k++) begin
            check("b2b_valid", {31'd0, d1_valid}, 32'd1);
            check("b2b_start", {31'd0, d1_start}, {31'd0, (k == 0) || (k == 9)});
            cycle();
            v1 = 1'b0;
        end
        check("b2b_end_valid", {31'd0, d1_valid}, 32'd0);
        fc1 += 2;
        check("b2b_fc", {16'd0, d1_fc}, fc1);

        // Buffer full back-pressure: 8'h12 shifting, 8'h34 buffered, 8'h56 waits
        in_data = 8'h12;
        v1 = 1'b1;
        cycle();
        in_data = 8'h34;
        check("bp_ready_first", {31'd0, d1_ready}, 32'd1);
        cycle();
        in_data = 8'h56;
        for (int k = 0; k < 8; k++) begin
            check("bp_ready_low", {31'd0, d1_ready}, 32'd0);
            cycle();
        end
        check("bp_ready_after_eof", {31'd0, d1_ready}, 32'd1);
        check("bp_start_34", {31'd0, d1_start}, 32'd1);
        cycle();
        v1 = 1'b0;
        check("bp_ready_full_again", {31'd0, d1_ready}, 32'd0);
        wait_idle();
        fc1 += 3;
        check("bp_fc", {16'd0, d1_fc}, fc1);

        // Slow tick: each bit held 4 cycles, 36 valid cycles
        bit_tick = 1'b0;
        in_data = 8'hF0;
        v1 = 1'b1;
        cycle();
        v1 = 1'b0;
        for (int c = 0; c < 40; c++) begin
            bit_tick = ((c % 4) == 3);
            check("slow_valid", {31'd0, d1_valid}, {31'd0, c < 36});
            if (c < 36) check("slow_bit", {31'd0, d1_out}, {31'd0, vecs[0].pat[0] | (c < 16)});
            cycle();
        end
        bit_tick = 1'b1;
        fc1++;
        check("slow_fc", {16'd0, d1_fc}, fc1);
        compare_stream();

        // Reset mid-frame with a byte buffered
        in_data = 8'hFF;
        v1 = 1'b1;
        cycle();
        in_data = 8'h81;
        cycle();
        v1 = 1'b0;
        cycle();
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, d1_valid}, 32'd0);
        check("mid_rst_out",   {31'd0, d1_out}, 32'd0);
        check("mid_rst_start", {31'd0, d1_start}, 32'd0);
        check("mid_rst_last",  {31'd0, d1_last}, 32'd0);
        check("mid_rst_fc",    {16'd0, d1_fc}, 32'd0);
        check("mid_rst_ready", {31'd0, d1_ready}, 32'd0);
        cycle();
        rst_n = 1'b1;
        got_q.delete();
        acc_q.delete();
        fc1 = 0;
        fc2 = 0;
        for (int k = 0; k < 3; k++) begin
            check("post_rst_idle", {31'd0, d1_valid}, 32'd0);
            cycle();
        end
        run_vec('{1'b0, 8'h81, 9'b1000_0001_0});
        compare_stream();

        // Random traffic against the frame-stream reference
        for (int c = 0; c < 3000; c++) begin
            in_data = 8'($urandom);
            v1 = ($urandom_range(0, 3) != 0);
            bit_tick = ($urandom_range(0, 1) == 1);
            cycle();
        end
        v1 = 1'b0;
        bit_tick = 1'b1;
        cycle();
        wait_idle();
        fc1 += acc_q.size();
        check("rand_fc", {16'd0, d1_fc}, fc1 % 65536);
        compare_stream();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
